// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffer: state encoding and default NOP.
// Used by pipe_stage_buf and pipe_sat_counter.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } buf_state_t;

    localparam int unsigned NOP_INSTR_DEF = 0;

endpackage : pipe_pkg

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: increments on i_inc, sticks at all-ones, cleared only by reset.
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == '1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : pipe_sat_counter

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between pipeline stages with sticky halt handling and flush.
// Define PIPE_STAGE_BUF_STATS_EN to add the o_stall_cycles backpressure counter.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned                  PC_SIZE          = 32,
    parameter int unsigned                  INSTRUCTION_SIZE = 32,
    parameter logic [INSTRUCTION_SIZE-1:0]  NOP_INSTR        = INSTRUCTION_SIZE'(NOP_INSTR_DEF),
    parameter int unsigned                  STAT_WIDTH       = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_flush,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [PC_SIZE-1:0]          i_next_seq_pc,
    input  logic [INSTRUCTION_SIZE-1:0] i_instruction,
    input  logic                        i_halt,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [PC_SIZE-1:0]          o_next_seq_pc,
    output logic [INSTRUCTION_SIZE-1:0] o_instruction,
    output logic                        o_halt,
    output logic                        o_halted
`ifdef PIPE_STAGE_BUF_STATS_EN
   ,output logic [STAT_WIDTH-1:0]       o_stall_cycles
`endif
);

    buf_state_t                  r_state;
    buf_state_t                  w_state_nxt;
    logic                        r_ready;
    logic                        r_halted;
    logic                        w_halted_nxt;

    logic [PC_SIZE-1:0]          r_main_pc;
    logic [INSTRUCTION_SIZE-1:0] r_main_instr;
    logic                        r_main_halt;
    logic [PC_SIZE-1:0]          r_skid_pc;
    logic [INSTRUCTION_SIZE-1:0] r_skid_instr;
    logic                        r_skid_halt;

    logic                        w_in;
    logic                        w_out;
    logic                        w_load_main;
    logic                        w_load_skid;
    logic                        w_promote;

    assign o_valid = (r_state != EMPTY);
    assign o_ready = r_ready;
    assign w_in    = i_valid && r_ready;
    assign w_out   = o_valid && i_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_promote   = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in) begin
                    w_state_nxt = ONE;
                    w_load_main = 1'b1;
                end
            end
            ONE: begin
                if (w_in && !w_out) begin
                    w_state_nxt = TWO;
                    w_load_skid = 1'b1;
                end else if (!w_in && w_out) begin
                    w_state_nxt = EMPTY;
                end else if (w_in && w_out) begin
                    w_load_main = 1'b1;
                end
            end
            TWO: begin
                // o_ready is low here, so only a drain can happen
                if (w_out) begin
                    w_state_nxt = ONE;
                    w_promote   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
        if (i_flush) begin
            w_state_nxt = EMPTY;
            w_load_main = 1'b0;
            w_load_skid = 1'b0;
            w_promote   = 1'b0;
        end
    end

    always_comb begin
        w_halted_nxt = r_halted || (w_in && i_halt);
        if (i_flush) begin
            w_halted_nxt = 1'b0;
        end
    end

    // o_ready is computed from next-state values so it never depends on i_ready combinationally
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= EMPTY;
            r_ready  <= 1'b1;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ready  <= (w_state_nxt != TWO) && !w_halted_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_main_pc    <= '0;
            r_main_instr <= NOP_INSTR;
            r_main_halt  <= 1'b0;
        end else if (w_load_main) begin
            r_main_pc    <= i_next_seq_pc;
            r_main_instr <= i_instruction;
            r_main_halt  <= i_halt;
        end else if (w_promote) begin
            r_main_pc    <= r_skid_pc;
            r_main_instr <= r_skid_instr;
            r_main_halt  <= r_skid_halt;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_skid_pc    <= '0;
            r_skid_instr <= NOP_INSTR;
            r_skid_halt  <= 1'b0;
        end else if (w_load_skid) begin
            r_skid_pc    <= i_next_seq_pc;
            r_skid_instr <= i_instruction;
            r_skid_halt  <= i_halt;
        end
    end

    always_comb begin
        o_next_seq_pc = '0;
        o_instruction = NOP_INSTR;
        o_halt        = 1'b0;
        if (r_state != EMPTY) begin
            o_next_seq_pc = r_main_pc;
            o_instruction = r_main_instr;
            o_halt        = r_main_halt;
        end
    end

    assign o_halted = r_halted;

`ifdef PIPE_STAGE_BUF_STATS_EN
    logic w_stall;

    assign w_stall = o_valid && !i_ready;

    pipe_sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_stall),
        .o_count (o_stall_cycles)
    );
`endif

endmodule : pipe_stage_buf

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_pipe_stage_buf;

    localparam int unsigned PCW  = 32;
    localparam int unsigned IW   = 32;
    localparam int unsigned SW   = 16;
    localparam logic [IW-1:0] TB_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic [IW-1:0]  instr;
        logic           halt;
    } ent_t;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           out_ready_dut;
    logic [PCW-1:0] in_pc;
    logic [IW-1:0]  in_instr;
    logic           in_halt;
    logic           out_valid;
    logic           ds_ready;
    logic [PCW-1:0] out_pc;
    logic [IW-1:0]  out_instr;
    logic           out_halt;
    logic           out_halted;
`ifdef PIPE_STAGE_BUF_STATS_EN
    logic [SW-1:0]  stall_cycles;
`endif

    int unsigned n_checks;
    int unsigned n_fail;

    ent_t        m_q[$];
    logic        m_ready;
    logic        m_halted;
    int unsigned m_stall;

    pipe_stage_buf #(
        .PC_SIZE          (PCW),
        .INSTRUCTION_SIZE (IW),
        .NOP_INSTR        (TB_NOP),
        .STAT_WIDTH       (SW)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_flush       (flush),
        .i_valid       (in_valid),
        .o_ready       (out_ready_dut),
        .i_next_seq_pc (in_pc),
        .i_instruction (in_instr),
        .i_halt        (in_halt),
        .o_valid       (out_valid),
        .i_ready       (ds_ready),
        .o_next_seq_pc (out_pc),
        .o_instruction (out_instr),
        .o_halt        (out_halt),
        .o_halted      (out_halted)
`ifdef PIPE_STAGE_BUF_STATS_EN
       ,.o_stall_cycles (stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ready  = 1'b1;
        m_halted = 1'b0;
        m_stall  = 0;
    endtask

    task automatic check_outputs();
        chk("valid", {63'd0, out_valid}, {63'd0, (m_q.size() != 0)});
        chk("ready", {63'd0, out_ready_dut}, {63'd0, m_ready});
        chk("halted", {63'd0, out_halted}, {63'd0, m_halted});
        if (m_q.size() != 0) begin
            chk("pc", 64'(out_pc), 64'(m_q[0].pc));
            chk("instr", 64'(out_instr), 64'(m_q[0].instr));
            chk("halt", {63'd0, out_halt}, {63'd0, m_q[0].halt});
        end else begin
            chk("pc_empty", 64'(out_pc), 64'd0);
            chk("instr_nop", 64'(out_instr), 64'(TB_NOP));
            chk("halt_empty", {63'd0, out_halt}, 64'd0);
        end
`ifdef PIPE_STAGE_BUF_STATS_EN
        chk("stall_cnt", 64'(stall_cycles), 64'(m_stall));
`endif
    endtask

    // Transaction-level update of the reference: pop/push on the handshakes, flush wins.
    task automatic model_clock();
        logic take;
        logic give;
        take = in_valid && m_ready;
        give = (m_q.size() != 0) && ds_ready;
        if ((m_q.size() != 0) && !ds_ready && (m_stall < (1 << SW) - 1)) m_stall++;
        if (flush) begin
            m_q.delete();
            m_halted = 1'b0;
        end else begin
            if (give) void'(m_q.pop_front());
            if (take) begin
                m_q.push_back('{pc: in_pc, instr: in_instr, halt: in_halt});
                if (in_halt) m_halted = 1'b1;
            end
        end
        m_ready = (m_q.size() < 2) && !m_halted;
    endtask

    // Inputs are applied just after a rising edge; outputs checked on the falling edge.
    task automatic step(input logic v, input logic [PCW-1:0] pc, input logic [IW-1:0] ins,
                        input logic h, input logic rdy, input logic fl);
        in_valid = v;
        in_pc    = pc;
        in_instr = ins;
        in_halt  = h;
        ds_ready = rdy;
        flush    = fl;
        @(negedge clk);
        check_outputs();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_pc    = '0;
        in_instr = '0;
        in_halt  = 1'b0;
        ds_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ready", {63'd0, out_ready_dut}, 64'd1);
        chk("rst_instr", 64'(out_instr), 64'(TB_NOP));

        // single pass-through with one-cycle latency
        step(1'b1, 32'h4, 32'h2008_0005, 1'b0, 1'b1, 1'b0);
        chk("lat_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_instr", 64'(out_instr), 64'h2008_0005);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

        // fill to two entries under backpressure, then drain in order
        step(1'b1, 32'h100, 32'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h104, 32'h22, 1'b0, 1'b0, 1'b0);
        chk("two_ready", {63'd0, out_ready_dut}, 64'd0);
        step(1'b1, 32'h108, 32'h33, 1'b0, 1'b0, 1'b0);
        chk("two_hold_a", 64'(out_instr), 64'h11);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("drain_b", 64'(out_instr), 64'h22);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

        // flush in TWO overrides simultaneous in/out
        step(1'b1, 32'h200, 32'hA1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h204, 32'hA2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h208, 32'hA3, 1'b0, 1'b1, 1'b1);
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_instr", 64'(out_instr), 64'(TB_NOP));
        chk("flush_ready", {63'd0, out_ready_dut}, 64'd1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

        // halt entry: sticky flag, upstream blocked, halt still delivered, flush clears
        step(1'b1, 32'h300, 32'hDEAD, 1'b1, 1'b0, 1'b0);
        chk("halt_flag", {63'd0, out_halted}, 64'd1);
        chk("halt_out", {63'd0, out_halt}, 64'd1);
        step(1'b1, 32'h304, 32'hBEEF, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h308, 32'hBEF0, 1'b0, 1'b1, 1'b0);
        chk("halt_block", {63'd0, out_ready_dut}, 64'd0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("halt_clr", {63'd0, out_halted}, 64'd0);
        chk("halt_clr_rdy", {63'd0, out_ready_dut}, 64'd1);

        // asynchronous reset mid-cycle while holding an entry
        step(1'b1, 32'h400, 32'h44, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_ready", {63'd0, out_ready_dut}, 64'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // stall counting
        step(1'b1, 32'h500, 32'h55, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_BUF_STATS_EN
        chk("stall5", 64'(stall_cycles), 64'd5);
`endif
        do_reset();
`ifdef PIPE_STAGE_BUF_STATS_EN
        chk("stall_rst", 64'(stall_cycles), 64'd0);
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 2) != 0), 32'($urandom), 32'($urandom),
                     1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 2) != 0),
                     1'($urandom_range(0, 24) == 0));
            end
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_buf
